// File: rtl/dcache_data_ctrl.sv
// dcache_data_ctrl
// Port sequencer and arbiter for the banked dcache data RAM. Each cycle one
// requester gets the RAM port. Refill beats win first, then writeback capture,
// then CPU accesses. Read data coming back from the RAM is steered to whoever
// issued the read.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cpu_*               CPU load/store: the request is accepted on cpu_addr_ok,
//                       and cpu_data_ok follows one cycle later
//   rf_*                refill beats, one word per beat; rf_last ends a line
//   wb_*                writeback: wb_req captures a whole line, which is then
//                       streamed out with a valid/ready handshake
//   ram_*               banked RAM port (one word per bank, shared index)
//
// Writeback FSM
//   state   | meaning
//   WB_IDLE | no writeback; a wb_req can be granted
//   WB_CAP  | all-bank read data is returning and gets latched into wbuf
//   WB_OUT  | streaming wbuf[out_cnt]; the RAM port is free for others
module dcache_data_ctrl #(
   parameter int INDEX_W   = 8,
   parameter int OFFSET_W  = 5,
   parameter int NUM_BANKS = 1 << (OFFSET_W - 2)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_req,
   input  logic                   cpu_wr,
   input  logic [3:0]             cpu_wstrb,
   input  logic [31:0]            cpu_addr,
   input  logic [31:0]            cpu_wdata,
   output logic                   cpu_addr_ok,
   output logic                   cpu_data_ok,
   output logic [31:0]            cpu_rdata,
   input  logic                   rf_valid,
   output logic                   rf_ready,
   input  logic [INDEX_W-1:0]     rf_index,
   input  logic [31:0]            rf_data,
   input  logic                   rf_last,
   input  logic                   wb_req,
   input  logic [INDEX_W-1:0]     wb_index,
   output logic                   wb_busy,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [31:0]            wb_data,
   output logic                   wb_last,
   output logic [NUM_BANKS-1:0]   ram_en,
   output logic [4*NUM_BANKS-1:0] ram_wen,
   output logic [INDEX_W-1:0]     ram_addr,
   output logic [31:0]            ram_wdata,
   input  logic [32*NUM_BANKS-1:0] ram_rdata
);

   localparam int BANK_W = OFFSET_W - 2;
   localparam logic [BANK_W-1:0] BANK_ONE = BANK_W'(1);
   localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(NUM_BANKS - 1);
   localparam logic [BANK_W-1:0] BANK_PEN = BANK_W'(NUM_BANKS - 2);

   typedef enum logic [1:0] {WB_IDLE, WB_CAP, WB_OUT} wb_state_t;
   typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_WB} rd_tag_t;

   wb_state_t          wb_state;
   rd_tag_t            rd_tag_q;
   logic [BANK_W-1:0]  rf_cnt;
   logic [BANK_W-1:0]  out_cnt;
   logic [BANK_W-1:0]  cpu_bank;
   logic [BANK_W-1:0]  cpu_bank_q;
   logic [INDEX_W-1:0] cpu_index;
   logic               rf_gnt;
   logic               wb_gnt;
   logic               cpu_gnt;
   logic               cpu_vld_q;
   logic [31:0]        wbuf [NUM_BANKS];
   logic               unused_addr_bits;

   assign cpu_bank  = cpu_addr[2 +: BANK_W];
   assign cpu_index = cpu_addr[OFFSET_W +: INDEX_W];
   assign unused_addr_bits = ^{cpu_addr[31:OFFSET_W+INDEX_W], cpu_addr[1:0]};

   // Grants are gated by rst so that the RAM port and the handshakes go quiet
   // as soon as reset is asserted, without waiting for a clock edge.
   assign rf_gnt  = rst & rf_valid;
   assign wb_gnt  = rst & ~rf_valid & wb_req & (wb_state == WB_IDLE);
   assign cpu_gnt = rst & cpu_req & ~rf_valid & ~wb_gnt;

   assign rf_ready    = rst;
   assign cpu_addr_ok = cpu_gnt;
   assign cpu_data_ok = cpu_vld_q;
   assign cpu_rdata   = (rd_tag_q == RD_CPU) ? ram_rdata[{cpu_bank_q, 5'b00000} +: 32] : '0;
   assign wb_data     = wb_valid ? wbuf[out_cnt] : '0;

   always_comb begin
      ram_en    = '0;
      ram_wen   = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (rf_gnt) begin
         ram_en[rf_cnt]                 = 1'b1;
         ram_wen[{rf_cnt, 2'b00} +: 4]  = 4'hF;
         ram_addr                       = rf_index;
         ram_wdata                      = rf_data;
      end else if (wb_gnt) begin
         ram_en   = '1;
         ram_addr = wb_index;
      end else if (cpu_gnt) begin
         ram_en[cpu_bank] = 1'b1;
         ram_addr         = cpu_index;
         if (cpu_wr) begin
            ram_wen[{cpu_bank, 2'b00} +: 4] = cpu_wstrb;
            ram_wdata                       = cpu_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_cnt     <= '0;
         cpu_vld_q  <= 1'b0;
         cpu_bank_q <= '0;
         rd_tag_q   <= RD_NONE;
      end else begin
         // rf_last always realigns to bank 0, even if a beat was lost upstream
         if (rf_gnt) begin
            if (rf_last || rf_cnt == BANK_MAX)
               rf_cnt <= '0;
            else
               rf_cnt <= rf_cnt + BANK_ONE;
         end
         cpu_vld_q <= cpu_gnt;
         if (cpu_gnt)
            cpu_bank_q <= cpu_bank;
         if (wb_gnt)
            rd_tag_q <= RD_WB;
         else if (cpu_gnt && !cpu_wr)
            rd_tag_q <= RD_CPU;
         else
            rd_tag_q <= RD_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_tag_q == RD_WB) begin
         for (int b = 0; b < NUM_BANKS; b++)
            wbuf[b] <= ram_rdata[b*32 +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_state <= WB_IDLE;
         out_cnt  <= '0;
         wb_busy  <= 1'b0;
         wb_valid <= 1'b0;
         wb_last  <= 1'b0;
      end else begin
         case (wb_state)
            WB_IDLE: begin
               if (wb_gnt) begin
                  wb_state <= WB_CAP;
                  wb_busy  <= 1'b1;
               end
            end
            WB_CAP: begin
               out_cnt  <= '0;
               wb_valid <= 1'b1;
               wb_last  <= 1'b0;
               wb_state <= WB_OUT;
            end
            WB_OUT: begin
               if (wb_ready) begin
                  if (out_cnt == BANK_MAX) begin
                     wb_state <= WB_IDLE;
                     wb_busy  <= 1'b0;
                     wb_valid <= 1'b0;
                     wb_last  <= 1'b0;
                  end else begin
                     out_cnt <= out_cnt + BANK_ONE;
                     wb_last <= (out_cnt == BANK_PEN);
                  end
               end
            end
            default: wb_state <= WB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
module tb_dcache_data_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req, cpu_wr;
   logic [3:0]   cpu_wstrb;
   logic [31:0]  cpu_addr, cpu_wdata;
   logic         cpu_addr_ok, cpu_data_ok;
   logic [31:0]  cpu_rdata;
   logic         rf_valid, rf_ready, rf_last;
   logic [7:0]   rf_index;
   logic [31:0]  rf_data;
   logic         wb_req, wb_busy, wb_valid, wb_ready, wb_last;
   logic [7:0]   wb_index;
   logic [31:0]  wb_data;
   logic [7:0]   ram_en;
   logic [31:0]  ram_wen;
   logic [7:0]   ram_addr;
   logic [31:0]  ram_wdata;
   logic [255:0] ram_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem [8][256];

   always #5 clk = ~clk;

   dcache_data_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wstrb(cpu_wstrb), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
      .cpu_rdata(cpu_rdata),
      .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_index(rf_index), .rf_data(rf_data),
      .rf_last(rf_last),
      .wb_req(wb_req), .wb_index(wb_index), .wb_busy(wb_busy), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_data(wb_data), .wb_last(wb_last),
      .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // single-port banks with byte writes and one-cycle read latency
   always @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (ram_en[b]) begin
            for (int k = 0; k < 4; k++)
               if (ram_wen[b*4+k]) mem[b][ram_addr][k*8 +: 8] <= ram_wdata[k*8 +: 8];
            ram_rdata[b*32 +: 32] <= mem[b][ram_addr];
         end
      end
   end

   task automatic idle_inputs();
      cpu_req = 0; cpu_wr = 0; cpu_wstrb = 0; cpu_addr = 0; cpu_wdata = 0;
      rf_valid = 0; rf_index = 0; rf_data = 0; rf_last = 0;
      wb_req = 0; wb_index = 0; wb_ready = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      cpu_req = 1; cpu_addr = 32'h748; rf_valid = 0; wb_req = 1; wb_index = 8'h3A;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (rf_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rf_ready: got %b exp 0", rf_ready); end
      n_chk++; if (cpu_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_addr_ok: got %b exp 0", cpu_addr_ok); end
      n_chk++; if (cpu_data_ok !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_cpu_out: got ok=%b rdata=%h exp 0/0", cpu_data_ok, cpu_rdata); end
      n_chk++; if (ram_en !== 8'h00 || ram_wen !== 32'h0) begin n_fail++; $display("FAIL rst_ram: got en=%h wen=%h exp 0/0", ram_en, ram_wen); end
      n_chk++; if ({wb_busy, wb_valid, wb_last} !== 3'b000 || wb_data !== 32'h0) begin n_fail++; $display("FAIL rst_wb: got busy/valid/last=%b data=%h exp 000/0", {wb_busy, wb_valid, wb_last}, wb_data); end
      idle_inputs();
      rst = 1;
      #1;
      n_chk++; if (rf_ready !== 1'b1) begin n_fail++; $display("FAIL rf_ready_up: got %b exp 1", rf_ready); end
      step();
   endtask

   task automatic test_refill();
      logic [31:0] exp_wen;
      logic [7:0]  exp_en;
      for (int i = 0; i < 8; i++) begin
         rf_valid = 1; rf_index = 8'h3A; rf_data = 32'h10000000 + i; rf_last = (i == 7);
         #1;
         exp_en  = 8'h01 << i;
         exp_wen = 32'hF << (4*i);
         n_chk++; if (ram_en !== exp_en || ram_wen !== exp_wen) begin n_fail++; $display("FAIL refill_beat%0d: got en=%h wen=%h exp en=%h wen=%h", i, ram_en, ram_wen, exp_en, exp_wen); end
         n_chk++; if (ram_addr !== 8'h3A || ram_wdata !== 32'h10000000 + i || rf_ready !== 1'b1) begin n_fail++; $display("FAIL refill_data%0d: got addr=%h wdata=%h ready=%b", i, ram_addr, ram_wdata, rf_ready); end
         step();
      end
      rf_valid = 0; rf_last = 0;
   endtask

   task automatic test_cpu_load();
      cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h00000748;
      #1;
      n_chk++; if (cpu_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ld_addr_ok: got %b exp 1", cpu_addr_ok); end
      n_chk++; if (ram_en !== 8'h04 || ram_addr !== 8'h3A || ram_wen !== 32'h0) begin n_fail++; $display("FAIL ld_ram: got en=%h addr=%h wen=%h exp 04/3a/0", ram_en, ram_addr, ram_wen); end
      step();
      cpu_req = 0;
      #1;
      n_chk++; if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h10000002) begin n_fail++; $display("FAIL ld_data: got ok=%b rdata=%h exp 1/10000002", cpu_data_ok, cpu_rdata); end
      step();
      n_chk++; if (cpu_data_ok !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL ld_after: got ok=%b rdata=%h exp 0/0", cpu_data_ok, cpu_rdata); end
   endtask

   task automatic test_back_to_back();
      cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h00000748; cpu_wstrb = 4'b0010; cpu_wdata = 32'h0000AB00;
      #1;
      n_chk++; if (cpu_addr_ok !== 1'b1 || ram_en !== 8'h04 || ram_wen !== 32'h00000200) begin n_fail++; $display("FAIL st_ram: got ok=%b en=%h wen=%h exp 1/04/00000200", cpu_addr_ok, ram_en, ram_wen); end
      n_chk++; if (ram_wdata !== 32'h0000AB00 || ram_addr !== 8'h3A) begin n_fail++; $display("FAIL st_wdata: got %h addr=%h exp 0000ab00/3a", ram_wdata, ram_addr); end
      step();
      cpu_wr = 0; cpu_wstrb = 0; cpu_wdata = 0;
      #1;
      n_chk++; if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL st_done: got ok=%b rdata=%h exp 1/0", cpu_data_ok, cpu_rdata); end
      n_chk++; if (cpu_addr_ok !== 1'b1 || ram_en !== 8'h04) begin n_fail++; $display("FAIL b2b_accept: got ok=%b en=%h exp 1/04", cpu_addr_ok, ram_en); end
      step();
      cpu_req = 0;
      #1;
      n_chk++; if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h1000AB02) begin n_fail++; $display("FAIL b2b_load: got ok=%b rdata=%h exp 1/1000ab02", cpu_data_ok, cpu_rdata); end
      step();
   endtask

   task automatic test_store_zero_strobe();
      cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h0000074C; cpu_wstrb = 4'b0000; cpu_wdata = 32'hFFFFFFFF;
      #1;
      n_chk++; if (cpu_addr_ok !== 1'b1 || ram_en !== 8'h08 || ram_wen !== 32'h0) begin n_fail++; $display("FAIL st0_ram: got ok=%b en=%h wen=%h exp 1/08/0", cpu_addr_ok, ram_en, ram_wen); end
      step();
      cpu_wr = 0; cpu_wdata = 0;
      #1;
      n_chk++; if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL st0_done: got ok=%b rdata=%h exp 1/0", cpu_data_ok, cpu_rdata); end
      step();
      cpu_req = 0;
      #1;
      n_chk++; if (cpu_rdata !== 32'h10000003) begin n_fail++; $display("FAIL st0_unchanged: got %h exp 10000003", cpu_rdata); end
      step();
   endtask

   task automatic test_writeback();
      logic [31:0] exp_w [8];
      int k;
      for (int i = 0; i < 8; i++) exp_w[i] = 32'h10000000 + i;
      exp_w[2] = 32'h1000AB02;
      wb_req = 1; wb_index = 8'h3A; wb_ready = 0;
      #1;
      n_chk++; if (ram_en !== 8'hFF || ram_wen !== 32'h0 || ram_addr !== 8'h3A || wb_busy !== 1'b0) begin n_fail++; $display("FAIL wb_grant: got en=%h wen=%h addr=%h busy=%b", ram_en, ram_wen, ram_addr, wb_busy); end
      step();
      n_chk++; if (wb_busy !== 1'b1 || wb_valid !== 1'b0 || ram_en !== 8'h00) begin n_fail++; $display("FAIL wb_cap: got busy=%b valid=%b en=%h exp 1/0/00", wb_busy, wb_valid, ram_en); end
      step();
      k = 0;
      for (int c = 0; c < 32 && k < 8; c++) begin
         wb_ready = (c % 2 == 0);
         wb_req = (k < 7);
         #1;
         n_chk++; if (wb_valid !== 1'b1 || wb_data !== exp_w[k] || wb_last !== (k == 7)) begin n_fail++; $display("FAIL wb_word%0d: got valid=%b data=%h last=%b exp 1/%h/%b", k, wb_valid, wb_data, wb_last, exp_w[k], (k == 7)); end
         n_chk++; if (ram_en !== 8'h00 || wb_busy !== 1'b1) begin n_fail++; $display("FAIL wb_out_port: got en=%h busy=%b exp 00/1", ram_en, wb_busy); end
         if (wb_ready) k++;
         step();
      end
      wb_ready = 0; wb_req = 0;
      n_chk++; if (k != 8) begin n_fail++; $display("FAIL wb_count: got %0d handshakes exp 8", k); end
      #1;
      n_chk++; if ({wb_busy, wb_valid, wb_last} !== 3'b000) begin n_fail++; $display("FAIL wb_end: got busy/valid/last=%b exp 000", {wb_busy, wb_valid, wb_last}); end
      step();
   endtask

   task automatic test_rf_cnt();
      logic [7:0] exp_en [11];
      for (int i = 0; i < 9; i++) exp_en[i] = 8'h01 << (i % 8);
      exp_en[9]  = 8'h02;
      exp_en[10] = 8'h01;
      for (int i = 0; i < 11; i++) begin
         rf_valid = 1; rf_index = 8'h11; rf_data = 32'hC0DE0000 + i; rf_last = (i >= 9);
         #1;
         n_chk++; if (ram_en !== exp_en[i]) begin n_fail++; $display("FAIL rfcnt_beat%0d: got en=%h exp %h", i, ram_en, exp_en[i]); end
         step();
      end
      rf_valid = 0; rf_last = 0;
   endtask

   task automatic test_priority();
      int n;
      rf_valid = 1; rf_index = 8'h20; rf_data = 32'h55; rf_last = 1;
      wb_req = 1; wb_index = 8'h3A;
      cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h00000748;
      #1;
      n_chk++; if (ram_en !== 8'h01 || ram_wen !== 32'hF || ram_addr !== 8'h20 || cpu_addr_ok !== 1'b0) begin n_fail++; $display("FAIL pri_refill: got en=%h wen=%h addr=%h ok=%b", ram_en, ram_wen, ram_addr, cpu_addr_ok); end
      step();
      rf_valid = 0; rf_last = 0;
      #1;
      n_chk++; if (ram_en !== 8'hFF || ram_wen !== 32'h0 || ram_addr !== 8'h3A || cpu_addr_ok !== 1'b0) begin n_fail++; $display("FAIL pri_wb: got en=%h wen=%h addr=%h ok=%b", ram_en, ram_wen, ram_addr, cpu_addr_ok); end
      step();
      wb_req = 0;
      #1;
      n_chk++; if (cpu_addr_ok !== 1'b1 || ram_en !== 8'h04 || wb_busy !== 1'b1) begin n_fail++; $display("FAIL pri_cpu: got ok=%b en=%h busy=%b exp 1/04/1", cpu_addr_ok, ram_en, wb_busy); end
      step();
      cpu_req = 0;
      #1;
      n_chk++; if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h1000AB02 || wb_data !== 32'h10000000) begin n_fail++; $display("FAIL pri_data: got ok=%b rdata=%h wb=%h", cpu_data_ok, cpu_rdata, wb_data); end
      wb_ready = 1;
      n = 0;
      while (wb_busy === 1'b1 && n < 20) begin
         step();
         n++;
      end
      wb_ready = 0;
      n_chk++; if (wb_busy !== 1'b0) begin n_fail++; $display("FAIL pri_wb_drain: got busy=%b after %0d cycles exp 0", wb_busy, n); end
      step();
   endtask

   task automatic test_reset_mid();
      wb_req = 1; wb_index = 8'h3A;
      step();
      wb_req = 0;
      for (int i = 0; i < 4; i++) begin
         rf_valid = 1; rf_index = 8'h40; rf_data = 32'hA0 + i; rf_last = 0;
         #1;
         if (i == 0) begin
            n_chk++; if (ram_en !== 8'h01) begin n_fail++; $display("FAIL mid_beat0: got en=%h exp 01", ram_en); end
         end
         step();
      end
      rf_valid = 0;
      cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h00000748;
      step();
      cpu_req = 0;
      #1;
      n_chk++; if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h1000AB02 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got ok=%b rdata=%h wbv=%b", cpu_data_ok, cpu_rdata, wb_valid); end
      rf_valid = 1; rf_index = 8'h40; cpu_req = 1;
      rst = 0;
      #1;
      n_chk++; if (rf_ready !== 1'b0 || cpu_addr_ok !== 1'b0 || cpu_data_ok !== 1'b0 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_cpu: got rdy=%b aok=%b dok=%b rdata=%h", rf_ready, cpu_addr_ok, cpu_data_ok, cpu_rdata); end
      n_chk++; if ({wb_busy, wb_valid, wb_last} !== 3'b000 || wb_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_wb: got busy/valid/last=%b data=%h", {wb_busy, wb_valid, wb_last}, wb_data); end
      n_chk++; if (ram_en !== 8'h00 || ram_wen !== 32'h0) begin n_fail++; $display("FAIL mid_rst_ram: got en=%h wen=%h exp 0/0", ram_en, ram_wen); end
      cpu_req = 0;
      step();
      rf_index = 8'h41; rf_data = 32'hB0; rf_last = 0;
      rst = 1;
      #1;
      n_chk++; if (ram_en !== 8'h01 || ram_wen !== 32'hF || rf_ready !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got en=%h wen=%h rdy=%b exp 01/f/1", ram_en, ram_wen, rf_ready); end
      step();
      rf_valid = 0;
      step();
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      test_reset();
      test_refill();
      test_cpu_load();
      test_back_to_back();
      test_store_zero_strobe();
      test_writeback();
      test_rf_cnt();
      test_priority();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_data_ctrl.md
Name: dcache_data_ctrl

Overview:
Port sequencer and arbiter for the banked dcache data RAM. The RAM has NUM_BANKS single-port word banks, each with a 4-bit byte write enable and a shared line index taken from addr[12:5]. The block shares the RAM among three requesters: refill beats from the AXI read return, dirty-line capture for writeback, and CPU load/store accesses. It also steers read data back to the requester that issued the read.

Parameters:
INDEX_W, 8, line index width (addr[12:5])
OFFSET_W, 5, byte offset width within a line (32-byte line)
NUM_BANKS, 8, words per line, fixed at 2^(OFFSET_W-2); the bank of an address is addr[4:2]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request
cpu_wr  in  1  1 = store, 0 = load
cpu_wstrb  in  4  store byte enables
cpu_addr  in  32  access address
cpu_wdata  in  32  store data
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  access complete; load data valid
cpu_rdata  out  32  load data
rf_valid  in  1  refill beat valid
rf_ready  out  1  refill beat accepted
rf_index  in  INDEX_W  refill line index
rf_data  in  32  refill word
rf_last  in  1  final refill beat
wb_req  in  1  request capture of a line for writeback
wb_index  in  INDEX_W  index of the line to write back
wb_busy  out  1  writeback in progress
wb_valid  out  1  writeback word valid
wb_ready  in  1  writeback word consumed
wb_data  out  32  writeback word
wb_last  out  1  final writeback word
ram_en  out  NUM_BANKS  per-bank enable
ram_wen  out  4*NUM_BANKS  per-bank byte write enable
ram_addr  out  INDEX_W  shared bank index
ram_wdata  out  32  shared write data
ram_rdata  in  32*NUM_BANKS  bank read data, valid one cycle after a read-enable

Behaviour:
- The RAM port is granted each cycle to one requester. Priority: refill beat > writeback capture > CPU.
- All RAM outputs are combinational from the grant. No grant: ram_en=0, ram_wen=0.

Refill:
- rf_ready=1 whenever rst is high. A beat transfers when rf_valid=1.
- Beat counter rf_cnt (0..NUM_BANKS-1) selects the bank. Each beat drives ram_en[rf_cnt]=1, wen=4'hF, addr=rf_index, wdata=rf_data.
- rf_cnt increments per beat and wraps after NUM_BANKS-1. rf_last forces rf_cnt to 0 regardless of its current value.

Writeback:
- States WB_IDLE, WB_CAP, WB_OUT.
- WB_IDLE: wb_req=1 and rf_valid=0 → grant. All ram_en=1, wen=0, addr=wb_index. Next state WB_CAP, wb_busy=1.
- WB_CAP: latch all ram_rdata into an 8-word buffer, set out_cnt=0, go to WB_OUT. The RAM port is free to other requesters this cycle.
- WB_OUT: wb_valid=1 and wb_data=buf[out_cnt]. wb_last=1 when out_cnt=NUM_BANKS-1. Each wb_valid&wb_ready handshake increments out_cnt.
- The last handshake returns to WB_IDLE with wb_busy=0. The RAM port is free throughout WB_OUT.
- wb_req is ignored while wb_busy=1.

CPU:
- cpu_addr_ok = cpu_req & ~rf_valid & ~(writeback grant this cycle). It is combinational.
- On accept: bank=cpu_addr[4:2], addr=cpu_addr[12:5], ram_en[bank]=1.
- A store drives ram_wen[bank]=cpu_wstrb and wdata=cpu_wdata. A store with wstrb=0 is still accepted and completes.
- cpu_data_ok=1 exactly one cycle after accept. Load data: cpu_rdata = slice of ram_rdata at the registered bank. cpu_rdata=0 when cpu_data_ok=0 or the access is a store.
- Back-to-back accepts are allowed, one access per cycle.

Read data steering:
- A registered tag (CPU or WB) records who issued each read. The same-cycle ram_rdata consumers (WB_CAP latch, CPU load return) never conflict, because only one read is issued per cycle.

Reset (rst=0, asynchronous):
- rf_ready=0, cpu_addr_ok=0, cpu_data_ok=0, cpu_rdata=0.
- wb_busy=0, wb_valid=0, wb_last=0, wb_data=0.
- ram_en=0, ram_wen=0.
- rf_cnt=0, out_cnt=0, state WB_IDLE.
- Reset mid-refill or mid-writeback abandons the operation. The next refill starts at bank 0.

Ordering:
- The block does not check hazards between requesters. The cache main FSM guarantees refill and writeback of the same index are not interleaved with CPU hits to that index.

Test Plan:
1. Refill 8 beats, rf_index=0x3A, rf_data=0x10000000+i, rf_last on beat 7 → beat i drives ram_en=1<<i, that bank's wen=0xF, ram_addr=0x3A; rf_ready=1 throughout; rf_cnt=0 after.
2. CPU load cpu_addr=0x00000748 after refill → cpu_addr_ok same cycle, ram_en=0x04, ram_addr=0x3A; next cycle cpu_data_ok=1, cpu_rdata=0x10000002.
3. CPU store 0x00000748, wstrb=4'b0010, wdata=0x0000AB00 → bank 2 wen=0010; next cycle cpu_data_ok=1, cpu_rdata=0; following load returns 0x1000AB02.
4. wb_req with wb_index=0x3A, wb_ready toggling 1,0,1,… → single all-bank read; 8 words 0x10000000..0x10000007 in order (word 2 = 0x1000AB02 if run after test 3); wb_last on the 8th; wb_busy falls after the last handshake.
5. rf_valid, wb_req and cpu_req asserted together → refill granted; cpu_addr_ok=0, no writeback read; next cycle with rf_valid=0 → writeback granted, CPU still stalled; the following cycle → CPU accepted.
6. Drop rst after refill beat 3 → all outputs go to reset values immediately; after rst rises, a new refill writes its first beat to bank 0.
